// File: rtl/spi_master_dds.sv
// SPI master for the DDS/serial-config chips. It drains a show-ahead command FIFO,
// shifts words out MSB-first in any CPOL/CPHA mode, and pushes readback words to a response FIFO.
module spi_master_dds #(
  parameter int CLK_DIV_EVEN = 8,
  parameter int WORD_W       = 8,
  parameter int N_CS         = 4,
  parameter int THREE_WIRE   = 1,
  parameter int IO_UPD_TICKS = 2,
  localparam int CS_W = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              empty,
  input  logic [WORD_W-1:0] data_i,
  output logic              rdreq,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  output logic              sclk,
  output logic [N_CS-1:0]   n_cs,
  output logic              mosi,
  input  logic              miso,
  output logic              high_z,
  output logic              io_update,
  output logic [WORD_W-1:0] miso_reg,
  output logic              wrreq,
  output logic              busy
);

  localparam int PH_W = $clog2(CLK_DIV_EVEN);
  localparam int BC_W = $clog2(WORD_W);
  localparam int UC_W = (IO_UPD_TICKS > 1) ? $clog2(IO_UPD_TICKS) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV_EVEN - 1);
  localparam logic [PH_W-1:0] PH_Q    = PH_W'(CLK_DIV_EVEN / 4);
  localparam logic [PH_W-1:0] PH_H3   = PH_W'(3 * CLK_DIV_EVEN / 4);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [UC_W-1:0] UC_LAST = UC_W'(IO_UPD_TICKS - 1);
  localparam bit TW = (THREE_WIRE != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, GAP} state_t;

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph, ph_n;
  logic [BC_W-1:0]   bitcnt;
  logic [7:0]        widx;
  logic [UC_W-1:0]   ucnt;
  logic [WORD_W-1:0] shreg, cap;
  logic [N_CS-1:0]   cs_hit;
  logic              is_read, cpol_l, cpha_l, cpol_nx, sclk_nx;
  logic              tick, bit_last, start, word_end, load, drop, samp, shift_en, cap_ok;

  assign tick     = (ph == PH_LAST);
  assign ph_n     = tick ? '0 : ph + 1'b1;
  assign bit_last = (bitcnt == BC_LAST);
  assign start    = (state == IDLE) && tick && !empty;
  assign word_end = (state == SHIFT) && tick && bit_last;
  assign load     = start || (word_end && !empty);
  assign drop     = word_end && empty;
  assign cpol_nx  = start ? cpol : cpol_l;
  // CPHA=1 drives on the leading edge; bit 0 is already on the line from the load.
  assign shift_en = cpha_l ? ((ph_n == PH_Q) && (bitcnt != '0)) : tick;
  assign samp     = cpha_l ? (ph == PH_H3) : (ph == PH_Q);
  assign cap_ok   = TW ? (is_read && (widx != 8'd0)) : 1'b1;
  assign mosi     = shreg[WORD_W-1];

  // An out-of-range cs_sel matches no lane, so no select is asserted.
  for (genvar i = 0; i < N_CS; i++) begin : g_cs
    assign cs_hit[i] = (cs_sel == CS_W'(i));
  end

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (drop) state_nx = is_read ? GAP : UPDATE;
      UPDATE:  if (tick && (ucnt == UC_LAST)) state_nx = GAP;
      GAP:     if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin : out_decode
    busy      = (state != IDLE);
    io_update = (state == UPDATE);
    high_z    = TW && is_read && (widx != 8'd0) && (state == SHIFT);
    // SCLK is registered from next-cycle state so its edges land on ph==Q / ph==H3.
    sclk_nx   = cpol_nx ^ ((state_nx == SHIFT) && (ph_n >= PH_Q) && (ph_n < PH_H3));
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      ph       <= '0;
      rdreq    <= 1'b0;
      wrreq    <= 1'b0;
      miso_reg <= '0;
      sclk     <= 1'b0;
      n_cs     <= '1;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      is_read  <= 1'b0;
      shreg    <= '0;
      cap      <= '0;
      bitcnt   <= '0;
      widx     <= '0;
      ucnt     <= '0;
    end else begin
      ph    <= ph_n;
      rdreq <= load;
      wrreq <= word_end && cap_ok;
      sclk  <= sclk_nx;
      if (word_end && cap_ok) miso_reg <= cap;
      if (start) begin
        cpol_l  <= cpol;
        cpha_l  <= cpha;
        is_read <= data_i[WORD_W-1];
        n_cs    <= ~cs_hit;
      end else if (drop) begin
        n_cs <= '1;
      end
      if (load) begin
        shreg  <= data_i;
        bitcnt <= '0;
        widx   <= start ? 8'd0 : ((widx == 8'hFF) ? widx : widx + 8'd1);
      end else if (state == SHIFT) begin
        if (tick)     bitcnt <= bitcnt + 1'b1;
        if (shift_en) shreg  <= {shreg[WORD_W-2:0], 1'b0};
      end
      if ((state == SHIFT) && samp) cap <= {cap[WORD_W-2:0], miso};
      if (state != UPDATE) ucnt <= '0;
      else if (tick)       ucnt <= ucnt + 1'b1;
    end
  end

endmodule
